// File: rtl/multiword_add_seq.sv
// Sequential WORDS*32-bit adder streaming one 32-bit word per clock through a ripple-carry slice.
// Define MULTIWORD_ADD_SUB_EN to add the in_sub port (A-B via inverted B and carry-in of 1).
module multiword_add_seq #(
  parameter int unsigned WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*WORDS-1:0]   in_a,
  input  logic [32*WORDS-1:0]   in_b,
  input  logic                  in_cin,
`ifdef MULTIWORD_ADD_SUB_EN
  input  logic                  in_sub,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*WORDS-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  out_ovf
);

  localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]                r_state;
  logic [IW-1:0]             r_idx;
  logic                      r_carry;
  logic [WORDS-1:0][31:0]    r_a;
  logic [WORDS-1:0][31:0]    r_b;
  logic [WORDS-1:0][31:0]    r_sum;
  logic [32*WORDS-1:0]       r_out_sum;
  logic                      r_out_cout;
  logic                      r_out_ovf;
`ifdef MULTIWORD_ADD_SUB_EN
  logic                      r_sub;
`endif

  logic                      w_accept;
  logic                      w_last;
  logic [31:0]               w_op_a;
  logic [31:0]               w_op_b;
  logic [31:0]               w_slice_sum;
  logic [32:0]               w_chain;
  logic                      w_init_carry;
  logic [WORDS-1:0][31:0]    w_sum_full;

  assign in_ready  = (r_state == StIdle) || ((r_state == StDone) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_idx == IW'(WORDS - 1));
  assign out_valid = (r_state == StDone);
  assign out_sum   = r_out_sum;
  assign out_cout  = r_out_cout;
  assign out_ovf   = r_out_ovf;

  assign w_op_a = r_a[r_idx];
`ifdef MULTIWORD_ADD_SUB_EN
  assign w_op_b       = r_sub ? ~r_b[r_idx] : r_b[r_idx];
  assign w_init_carry = in_sub ? 1'b1 : in_cin;
`else
  assign w_op_b       = r_b[r_idx];
  assign w_init_carry = in_cin;
`endif

  // 32-bit ripple-carry slice: the only combinational carry chain in the block
  always_comb begin
    w_chain[0] = r_carry;
    for (int i = 0; i < 32; i++) begin
      w_slice_sum[i] = w_op_a[i] ^ w_op_b[i] ^ w_chain[i];
      w_chain[i+1]   = (w_op_a[i] & w_op_b[i]) | (w_chain[i] & (w_op_a[i] ^ w_op_b[i]));
    end
  end

  always_comb begin
    w_sum_full        = r_sum;
    w_sum_full[r_idx] = w_slice_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_sum      <= '0;
      r_out_sum  <= '0;
      r_out_cout <= 1'b0;
      r_out_ovf  <= 1'b0;
`ifdef MULTIWORD_ADD_SUB_EN
      r_sub      <= 1'b0;
`endif
    end else if (w_accept) begin
      // Covers both IDLE accept and same-edge retire+accept from DONE
      r_state <= StRun;
      r_idx   <= '0;
      r_carry <= w_init_carry;
      r_a     <= in_a;
      r_b     <= in_b;
`ifdef MULTIWORD_ADD_SUB_EN
      r_sub   <= in_sub;
`endif
    end else begin
      case (r_state)
        StRun: begin
          r_sum[r_idx] <= w_slice_sum;
          r_carry      <= w_chain[32];
          r_idx        <= r_idx + 1'b1;
          if (w_last) begin
            r_out_sum  <= w_sum_full;
            r_out_cout <= w_chain[32];
            r_out_ovf  <= (w_op_a[31] == w_op_b[31]) && (w_slice_sum[31] != w_op_a[31]);
            r_state    <= StDone;
          end
        end
        StDone: begin
          if (out_ready) r_state <= StIdle;
        end
        StIdle: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
